fft32_iterative: RTL and testbench
==================================

Name: fft32_iterative

Overview:
- 32-point radix-2 decimation-in-time complex FFT on 8-bit signed fixed-point samples.
- Captures a 32-sample complex frame from wide parallel input buses and computes the transform iteratively with one butterfly per clock.
- Presents the 32 frequency bins on wide parallel output buses, held stable until the next frame completes.
- Sits between a parallel sample-vector producer and spectrum consumers; free-running, no handshake.

Parameters:
- N, 32, transform length (fixed; log2 N = 5 stages).
- DW, 8, sample/bin width, two's complement.
- TW, 9, twiddle width, signed Q1.7 (+1.0 = 128).

Ports:
- clk1  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Xn_vect_real  in  256  real parts of x[0..31]; x[i] at bits [8i+7:8i].
- Xn_vect_imag  in  256  imaginary parts, same packing.
- Xk_vect_real  out  256  real parts of X[0..31]; X[k] at bits [8k+7:8k], registered.
- Xk_vect_imag  out  256  imaginary parts, same packing, registered.

Behaviour:
- Reset: both output buses = 0, working memory cleared, FSM to LOAD, stage/butterfly counters = 0. Reset mid-CALC aborts the frame; outputs stay 0 until the next full frame completes.
- FSM, period 82 cycles, repeating forever:
  - LOAD (1 cycle): sample both input buses; write x[i] into working memory at address bitrev5(i).
  - CALC (80 cycles): stage s = 0..4, butterfly j = 0..15 per stage, one butterfly per cycle.
  - DONE (1 cycle): copy working memory (natural order) into the output registers, then return to LOAD.
- Latency: output registers update 81 edges after the LOAD edge that sampled the input. Inputs between LOAD edges are ignored.
- Butterfly addressing, stage s:
  - h = 2^s, k = j mod h, top = (j >> s)*2h + k, bot = top + h.
  - Twiddle index m = k << (4-s), range 0..15.
- Twiddle ROM (16 entries):
  - Wr[m] = round(128*cos(2*pi*m/32)).
  - Wi[m] = -round(128*sin(2*pi*m/32)).
  - Example: W[0] = (128, 0); W[8] = (0, -128).
- Butterfly arithmetic, with a = mem[top], b = mem[bot]:
  - Complex product t = b*W; each real partial-sum pair is computed at full precision, then arithmetic shift right by 7 (truncation), held at 10 bits.
  - top' = (a + t) >>> 1, bot' = (a - t) >>> 1, computed at 11 bits.
  - Each component saturates to [-128, 127] before write-back.
  - Both results are written in the same cycle (read-before-write per butterfly).
- Overall result is DFT/32 with per-stage truncation toward minus infinity.
- No overflow flags and no valid strobe; output registers change only in DONE.

Test Plan:
- Reset, all-zero input, run 3 frames -> both output buses remain 256'h0 throughout.
- x[0] = 64 real, all else 0 -> after DONE every X[k] = (2, 0), i.e. Xk_vect_real = 256'h0202...02, Xk_vect_imag = 0.
- All x[i] real = 32, imag = 0 -> X[0] = (32, 0), X[1..31] = (0, 0).
- x[i] real = +64 for even i, -64 (0xC0) for odd i -> X[16] = (64, 0), all other bins 0.
- x[0] imag = 64, all else 0 -> every X[k] = (0, 2).
- Start the impulse frame, assert rst for 1 cycle at CALC cycle 40 -> outputs stay 0 until 82 cycles after reset release; then the impulse result appears. Verify the output bus changes only on DONE edges.

Source files
------------

// File: rtl/fft32_iterative.sv
// rtl/fft32_iterative.sv - 32-point iterative radix-2 DIT FFT, one butterfly per clock
module fft32_iterative (
  input  logic         clk1,
  input  logic         rst,
  input  logic [255:0] Xn_vect_real,
  input  logic [255:0] Xn_vect_imag,
  output logic [255:0] Xk_vect_real,
  output logic [255:0] Xk_vect_imag
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        stage_q, stage_d;
  logic [3:0]        bfly_q, bfly_d;
  logic signed [7:0] mem_re_q [32];
  logic signed [7:0] mem_im_q [32];
  logic signed [7:0] mem_re_d [32];
  logic signed [7:0] mem_im_d [32];
  logic [255:0]      out_re_q, out_re_d;
  logic [255:0]      out_im_q, out_im_d;

  logic [4:0]         h, k, top, bot;
  logic [3:0]         tw_idx;
  logic signed [7:0]  a_re, a_im, b_re, b_im;
  logic signed [8:0]  w_re, w_im;
  logic signed [16:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [17:0] sum_re, sum_im;
  logic signed [9:0]  t_re, t_im;
  logic signed [10:0] top_re, top_im, bot_re, bot_im;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // round(128*cos(2*pi*m/32))
  function automatic logic signed [8:0] tw_cos(input logic [3:0] m);
    case (m)
      4'd0:    return 9'sd128;
      4'd1:    return 9'sd126;
      4'd2:    return 9'sd118;
      4'd3:    return 9'sd106;
      4'd4:    return 9'sd91;
      4'd5:    return 9'sd71;
      4'd6:    return 9'sd49;
      4'd7:    return 9'sd25;
      4'd8:    return 9'sd0;
      4'd9:    return -9'sd25;
      4'd10:   return -9'sd49;
      4'd11:   return -9'sd71;
      4'd12:   return -9'sd91;
      4'd13:   return -9'sd106;
      4'd14:   return -9'sd118;
      default: return -9'sd126;
    endcase
  endfunction

  // -round(128*sin(2*pi*m/32))
  function automatic logic signed [8:0] tw_msin(input logic [3:0] m);
    case (m)
      4'd0:    return 9'sd0;
      4'd1:    return -9'sd25;
      4'd2:    return -9'sd49;
      4'd3:    return -9'sd71;
      4'd4:    return -9'sd91;
      4'd5:    return -9'sd106;
      4'd6:    return -9'sd118;
      4'd7:    return -9'sd126;
      4'd8:    return -9'sd128;
      4'd9:    return -9'sd126;
      4'd10:   return -9'sd118;
      4'd11:   return -9'sd106;
      4'd12:   return -9'sd91;
      4'd13:   return -9'sd71;
      4'd14:   return -9'sd49;
      default: return -9'sd25;
    endcase
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [10:0] v);
    if (v > 11'sd127) begin
      return 8'h7F;
    end else if (v < -11'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

  // Butterfly addressing and arithmetic for the current (stage, butterfly) pair
  always_comb begin
    h      = 5'd1 << stage_q;
    k      = {1'b0, bfly_q} & (h - 5'd1);
    top    = (({1'b0, bfly_q} >> stage_q) << (stage_q + 3'd1)) | k;
    bot    = top + h;
    tw_idx = k[3:0] << (3'd4 - stage_q);

    a_re = mem_re_q[top];
    a_im = mem_im_q[top];
    b_re = mem_re_q[bot];
    b_im = mem_im_q[bot];
    w_re = tw_cos(tw_idx);
    w_im = tw_msin(tw_idx);

    p_rr = 17'(b_re) * 17'(w_re);
    p_ii = 17'(b_im) * 17'(w_im);
    p_ri = 17'(b_re) * 17'(w_im);
    p_ir = 17'(b_im) * 17'(w_re);

    // Full-precision partial sums, then truncate (floor) back to 10 bits
    sum_re = 18'(p_rr) - 18'(p_ii);
    sum_im = 18'(p_ri) + 18'(p_ir);
    t_re   = 10'(sum_re >>> 7);
    t_im   = 10'(sum_im >>> 7);

    // Halve every stage so the frame result is DFT/32
    top_re = (11'(a_re) + 11'(t_re)) >>> 1;
    top_im = (11'(a_im) + 11'(t_im)) >>> 1;
    bot_re = (11'(a_re) - 11'(t_re)) >>> 1;
    bot_im = (11'(a_im) - 11'(t_im)) >>> 1;
  end

  // Next-state: LOAD captures in bit-reversed order, CALC runs 5x16 butterflies, DONE publishes
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    bfly_d   = bfly_q;
    mem_re_d = mem_re_q;
    mem_im_d = mem_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;

    case (state_q)
      ST_LOAD: begin
        for (int i = 0; i < 32; i++) begin
          mem_re_d[bitrev5(5'(i))] = Xn_vect_real[8*i +: 8];
          mem_im_d[bitrev5(5'(i))] = Xn_vect_imag[8*i +: 8];
        end
        stage_d = 3'd0;
        bfly_d  = 4'd0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        mem_re_d[top] = sat8(top_re);
        mem_im_d[top] = sat8(top_im);
        mem_re_d[bot] = sat8(bot_re);
        mem_im_d[bot] = sat8(bot_im);
        if (bfly_q == 4'd15) begin
          bfly_d = 4'd0;
          if (stage_q == 3'd4) begin
            stage_d = 3'd0;
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + 3'd1;
          end
        end else begin
          bfly_d = bfly_q + 4'd1;
        end
      end
      ST_DONE: begin
        for (int i = 0; i < 32; i++) begin
          out_re_d[8*i +: 8] = mem_re_q[i];
          out_im_d[8*i +: 8] = mem_im_q[i];
        end
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any frame in flight
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      stage_q  <= 3'd0;
      bfly_q   <= 4'd0;
      out_re_q <= '0;
      out_im_q <= '0;
      for (int i = 0; i < 32; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      bfly_q   <= bfly_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      for (int i = 0; i < 32; i++) begin
        mem_re_q[i] <= mem_re_d[i];
        mem_im_q[i] <= mem_im_d[i];
      end
    end
  end

  assign Xk_vect_real = out_re_q;
  assign Xk_vect_imag = out_im_q;

endmodule

// File: tb/tb_fft32_iterative.sv
// tb/tb_fft32_iterative.sv - directed table-driven bench for fft32_iterative
module tb_fft32_iterative;

  logic         clk1;
  logic         rst;
  logic [255:0] Xn_vect_real;
  logic [255:0] Xn_vect_imag;
  logic [255:0] Xk_vect_real;
  logic [255:0] Xk_vect_imag;

  fft32_iterative dut (
    .clk1         (clk1),
    .rst          (rst),
    .Xn_vect_real (Xn_vect_real),
    .Xn_vect_imag (Xn_vect_imag),
    .Xk_vect_real (Xk_vect_real),
    .Xk_vect_imag (Xk_vect_imag)
  );

  typedef struct {
    string        name;
    logic [255:0] in_re;
    logic [255:0] in_im;
    logic [255:0] exp_re;
    logic [255:0] exp_im;
  } vec_t;

  vec_t tbl [8];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rep8(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] lane(input int idx, input logic [7:0] b);
    logic [255:0] v;
    v = '0;
    v[8*idx +: 8] = b;
    return v;
  endfunction

  // Reset, present a frame, check nothing moves before DONE and the bins at DONE
  task automatic run_vec(input vec_t v);
    rst = 1'b1;
    Xn_vect_real = '0;
    Xn_vect_imag = '0;
    tick(2);
    Xn_vect_real = v.in_re;
    Xn_vect_imag = v.in_im;
    rst = 1'b0;
    tick(1);
    Xn_vect_real = {8{$urandom}};
    Xn_vect_imag = {8{$urandom}};
    tick(80);
    chk({v.name, "_pre_done"}, Xk_vect_real | Xk_vect_imag, '0);
    tick(1);
    chk({v.name, "_re"}, Xk_vect_real, v.exp_re);
    chk({v.name, "_im"}, Xk_vect_imag, v.exp_im);
  endtask

  int v7_tr [16] = '{2, 1, 1, 1, 1, 1, 0, 0, 0, -1, -1, -2, -2, -2, -2, -2};
  int v7_br [16] = '{-2, -2, -2, -2, -1, -1, -1, 0, 0, 0, 1, 1, 1, 2, 2, 2};
  int v7_ti [16] = '{0, -1, -1, -2, -2, -2, -2, -2, -2, -2, -2, -2, -2, -2, -1, -1};
  int v7_bi [16] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 0};

  logic [255:0] imp_re, neg1_re, prev_re, prev_im;
  int           bad;
  int           off_done;

  initial begin
    rst = 1'b1;
    Xn_vect_real = '0;
    Xn_vect_imag = '0;

    tbl[0] = '{"zero",     '0,                 '0,             '0,                '0};
    tbl[1] = '{"imp_re",   lane(0, 8'h40),     '0,             rep8(8'h02),       '0};
    tbl[2] = '{"dc32",     rep8(8'h20),        '0,             lane(0, 8'h20),    '0};
    tbl[3] = '{"alt",      {16{16'hC040}},     '0,             lane(16, 8'h40),   '0};
    tbl[4] = '{"imp_im",   '0,                 lane(0, 8'h40), '0,                rep8(8'h02)};
    tbl[5] = '{"imp16",    lane(16, 8'h40),    '0,             {16{16'hFE02}},    '0};
    tbl[6] = '{"imp_neg1", lane(0, 8'hFF),     '0,             rep8(8'hFF),       '0};
    tbl[7] = '{"imp1",     lane(1, 8'h40),     '0,             '0,                '0};
    for (int i = 0; i < 16; i++) begin
      tbl[7].exp_re[8*i +: 8]      = 8'(v7_tr[i]);
      tbl[7].exp_re[8*(i+16) +: 8] = 8'(v7_br[i]);
      tbl[7].exp_im[8*i +: 8]      = 8'(v7_ti[i]);
      tbl[7].exp_im[8*(i+16) +: 8] = 8'(v7_bi[i]);
    end

    tick(3);
    chk("reset_out", Xk_vect_real | Xk_vect_imag, '0);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i]);
    end

    // All-zero input over three full frames: outputs must never leave zero
    rst = 1'b1;
    Xn_vect_real = '0;
    Xn_vect_imag = '0;
    tick(2);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 246; n++) begin
      tick(1);
      if ((Xk_vect_real | Xk_vect_imag) != '0) bad++;
    end
    chk("zero_3frames", 256'(bad), '0);

    // Impulse frame, then reset in the middle of the next frame's CALC
    imp_re  = lane(0, 8'h40);
    neg1_re = lane(0, 8'hFF);
    rst = 1'b1;
    tick(2);
    Xn_vect_real = imp_re;
    Xn_vect_imag = '0;
    rst = 1'b0;
    tick(82);
    chk("abort_pre_re", Xk_vect_real, rep8(8'h02));
    tick(1);
    tick(40);
    rst = 1'b1;
    tick(1);
    chk("abort_rst_clears", Xk_vect_real | Xk_vect_imag, '0);
    rst = 1'b0;
    bad = 0;
    off_done = 0;
    prev_re = Xk_vect_real;
    prev_im = Xk_vect_imag;
    for (int n = 1; n <= 164; n++) begin
      tick(1);
      if (n == 5) Xn_vect_real = neg1_re;
      if (n < 82 && (Xk_vect_real | Xk_vect_imag) != '0) bad++;
      if (n == 82) begin
        chk("abort_result_re", Xk_vect_real, rep8(8'h02));
        chk("abort_result_im", Xk_vect_imag, '0);
      end
      if ((Xk_vect_real !== prev_re || Xk_vect_imag !== prev_im) && (n % 82) != 0) off_done++;
      prev_re = Xk_vect_real;
      prev_im = Xk_vect_imag;
    end
    chk("abort_zero_hold", 256'(bad), '0);
    chk("next_frame_re", Xk_vect_real, rep8(8'hFF));
    chk("change_only_on_done", 256'(off_done), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
